plru_repl_ctrl: RTL

Sequential tree-PLRU replacement controller for the last-level cache model. It holds per-set PLRU state for NUM_SETS sets of WAYS ways. It services touch (hit update), victim (allocation) and flush requests over a valid/ready handshake. Victim selection prefers invalid ways, and every operation read-modify-writes the set's tree in one step.

---
 rtl/cache_define_pkg.sv | 15 +
 rtl/plru_tree_logic.sv | 36 +++
 rtl/plru_repl_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/cache_define_pkg.sv
// cache_define: shared opcodes, FSM states and default geometry for the LLC model.
package cache_define;
  typedef enum logic [1:0] {
    OP_TOUCH  = 2'd0,
    OP_VICTIM = 2'd1,
    OP_FLUSH  = 2'd2,
    OP_RSVD   = 2'd3
  } plru_op_e;
  typedef enum logic {ST_IDLE, ST_FLUSH} plru_state_e;
  localparam int NUM_SETS_DEF = 64;
  localparam int WAYS_DEF = 8;
  localparam int WAY_W = $clog2(WAYS_DEF);
  localparam int SET_W = $clog2(NUM_SETS_DEF);
  localparam int PLRU_BITS = WAYS_DEF - 1;
endpackage

// File: rtl/plru_tree_logic.sv
// plru_tree_logic: tree-PLRU victim walk and path update for one set.
module plru_tree_logic
  import cache_define::*;
#(
  parameter int WAYS = WAYS_DEF,
  localparam int WW = $clog2(WAYS),
  localparam int PB = WAYS - 1
) (
  input  logic [PB-1:0] tree_i,
  input  logic [WW-1:0] way_i,
  input  logic          walk_i,
  output logic [WW-1:0] victim_o,
  output logic [PB-1:0] tree_o
);
  logic [WW-1:0] touch_way;
  always_comb begin
    int n;
    n = 0;
    victim_o = '0;
    for (int l = WW - 1; l >= 0; l--) begin
      victim_o[l] = ~tree_i[n];
      n = tree_i[n] ? 2 * n + 1 : 2 * n + 2;
    end
  end
  // in walk mode the path of the walk result itself is written back
  assign touch_way = walk_i ? victim_o : way_i;
  always_comb begin
    int n;
    n = 0;
    tree_o = tree_i;
    for (int l = WW - 1; l >= 0; l--) begin
      tree_o[n] = touch_way[l];
      n = touch_way[l] ? 2 * n + 2 : 2 * n + 1;
    end
  end
endmodule

// File: rtl/plru_repl_ctrl.sv
// plru_repl_ctrl: per-set tree-PLRU state with touch/victim/flush request handling.
module plru_repl_ctrl
  import cache_define::*;
#(
  parameter int NUM_SETS = NUM_SETS_DEF,
  parameter int WAYS = WAYS_DEF,
  localparam int PB = WAYS - 1,
  localparam int WW = $clog2(WAYS),
  localparam int SW = $clog2(NUM_SETS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [SW-1:0]   req_set,
  input  logic [WW-1:0]   req_way,
  input  logic [WAYS-1:0] req_valid_mask,
  output logic            rsp_valid,
  output logic [WW-1:0]   rsp_way,
  output logic            rsp_was_invalid,
  output logic            busy
);
  plru_state_e   state_q;
  logic [PB-1:0] tree_q [NUM_SETS];
  logic [SW-1:0] cnt_q;
  logic          rsp_valid_q, rsp_inv_q;
  logic [WW-1:0] rsp_way_q, rsp_way_d, inv_way, walk_way, touch_way;
  logic [PB-1:0] tree_nxt;
  logic          accept, is_victim, all_valid, use_walk;
  assign req_ready = state_q == ST_IDLE;
  assign busy = state_q == ST_FLUSH;
  assign accept = req_valid && req_ready;
  assign is_victim = req_op == OP_VICTIM;
  assign all_valid = &req_valid_mask;
  assign use_walk = is_victim && all_valid;
  always_comb begin
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) inv_way = req_valid_mask[i] ? inv_way : WW'(i);
  end
  assign touch_way = (is_victim && !all_valid) ? inv_way : req_way;
  assign rsp_way_d = use_walk ? walk_way : touch_way;
  plru_tree_logic #(.WAYS(WAYS)) u_tree (
    .tree_i  (tree_q[req_set]),
    .way_i   (touch_way),
    .walk_i  (use_walk),
    .victim_o(walk_way),
    .tree_o  (tree_nxt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_way_q <= '0;
      rsp_inv_q <= 1'b0;
      for (int i = 0; i < NUM_SETS; i++) tree_q[i] <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q == ST_FLUSH) begin
        tree_q[cnt_q] <= '0;
        cnt_q <= cnt_q + 1'b1;
        if (&cnt_q) state_q <= ST_IDLE;
      end else if (accept) begin
        if (req_op == OP_FLUSH) begin
          state_q <= ST_FLUSH;
        end else if (req_op != OP_RSVD) begin
          tree_q[req_set] <= tree_nxt;
          rsp_valid_q <= 1'b1;
          rsp_way_q <= rsp_way_d;
          rsp_inv_q <= is_victim && !all_valid;
        end
      end
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_way = rsp_way_q;
  assign rsp_was_invalid = rsp_inv_q;
endmodule
